// File: rtl/simt_dmem_responder_pkg.sv
// Shared SIMT core types for the dmem responder: access size, responder state and
// the byte-enable helper used by the store path.
package pkg_opengpu;

  localparam int WARP_SIZE              = 32;
  localparam int DATA_WIDTH             = 32;
  localparam int ADDR_WIDTH             = 32;
  localparam int DMEM_NUM_BANKS_DEFAULT = 8;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'd0,
    MEM_HALF = 2'd1,
    MEM_WORD = 2'd2
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    RESP  = 2'd2
  } dmem_state_t;

  // Byte lanes of a 32-bit word touched by an access; off must already be aligned.
  function automatic logic [3:0] byte_en(mem_size_t size, logic [1:0] off);
    case (size)
      MEM_BYTE: byte_en = 4'b0001 << off;
      MEM_HALF: byte_en = 4'b0011 << {off[1], 1'b0};
      default:  byte_en = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/simt_dmem_responder_bank.sv
// One word-wide scratchpad bank: byte-enabled synchronous write, combinational read.
module dmem_bank #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [3:0]    be,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // NOTE: the storage array has no reset so it can map onto RAM macros; contents
  // are undefined until written.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int k = 0; k < 4; k++) begin
        if (be[k]) mem[addr][8*k +: 8] <= wdata[8*k +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/simt_dmem_responder.sv
// Banked warp-wide dmem responder: serializes bank conflicts, merges same-row lanes.
// Optional macro DMEM_MISALIGN_CHK_EN adds per-lane misalignment error reporting.
module simt_dmem_responder
  import pkg_opengpu::*;
#(
  parameter int NUM_BANKS  = DMEM_NUM_BANKS_DEFAULT,
  parameter int BANK_DEPTH = 1024
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  dmem_req,
  input  logic [WARP_SIZE-1:0]                  dmem_lane_valid,
  input  logic [WARP_SIZE-1:0][ADDR_WIDTH-1:0]  dmem_addr,
  input  logic [WARP_SIZE-1:0][DATA_WIDTH-1:0]  dmem_wdata,
  input  logic                                  dmem_we,
  input  mem_size_t                             dmem_size,
  output logic                                  dmem_ready,
  output logic                                  dmem_resp_valid,
  output logic [WARP_SIZE-1:0][DATA_WIDTH-1:0]  dmem_rdata,
  output logic [WARP_SIZE-1:0]                  dmem_lane_resp_valid,
  output logic [31:0]                           conflict_cycles
`ifdef DMEM_MISALIGN_CHK_EN
  ,
  output logic [WARP_SIZE-1:0]                  dmem_lane_err
`endif
);

  localparam int BANK_BITS = $clog2(NUM_BANKS);
  localparam int ROW_BITS  = $clog2(BANK_DEPTH);
  localparam int ROW_LSB   = 2 + BANK_BITS;
  localparam int ADDR_USED = ROW_LSB + ROW_BITS;

  dmem_state_t                         state_q, state_d;
  logic [WARP_SIZE-1:0]                mask_q, pending_q, serve, lane_ok;
  logic [WARP_SIZE-1:0][ADDR_WIDTH-1:0] addr_q;
  logic [WARP_SIZE-1:0][DATA_WIDTH-1:0] wdata_q;
  logic                                we_q, first_q;
  mem_size_t                           size_q;

  logic [BANK_BITS-1:0] lane_bank [WARP_SIZE];
  logic [ROW_BITS-1:0]  lane_row  [WARP_SIZE];
  logic [1:0]           lane_off  [WARP_SIZE];
  logic [DATA_WIDTH-1:0] load_data [WARP_SIZE];
  logic                 unused_addr_hi;

  logic [ROW_BITS-1:0]  leader_row  [NUM_BANKS];
  logic [NUM_BANKS-1:0] bank_we;
  logic [3:0]           bank_be     [NUM_BANKS];
  logic [31:0]          bank_wdata  [NUM_BANKS];
  logic [31:0]          bank_rdata  [NUM_BANKS];

  // Address decode; misaligned offsets are forced down to the access alignment.
  always_comb begin
    unused_addr_hi = 1'b0;
    for (int i = 0; i < WARP_SIZE; i++) begin
      lane_bank[i] = addr_q[i][2 +: BANK_BITS];
      lane_row[i]  = addr_q[i][ROW_LSB +: ROW_BITS];
      case (size_q)
        MEM_BYTE: lane_off[i] = addr_q[i][1:0];
        MEM_HALF: lane_off[i] = {addr_q[i][1], 1'b0};
        default:  lane_off[i] = 2'b00;
      endcase
      unused_addr_hi = unused_addr_hi ^ (^addr_q[i][ADDR_WIDTH-1:ADDR_USED]);
    end
  end

`ifdef DMEM_MISALIGN_CHK_EN
  logic [WARP_SIZE-1:0] misaligned;
  always_comb begin
    for (int i = 0; i < WARP_SIZE; i++) begin
      misaligned[i] = ((size_q == MEM_HALF) && addr_q[i][0]) ||
                      ((size_q == MEM_WORD) && (addr_q[i][1:0] != 2'b00));
    end
  end
  assign lane_ok = ~misaligned;
`else
  assign lane_ok = '1;
`endif

  // NOTE: blocking assignments in combinational logic give the loop sequential
  // meaning: scanning lanes high to low, the lowest pending lane writes last and
  // becomes its bank's leader.
  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) leader_row[b] = '0;
    for (int i = WARP_SIZE - 1; i >= 0; i--) begin
      if (pending_q[i]) leader_row[lane_bank[i]] = lane_row[i];
    end
  end

  always_comb begin
    for (int i = 0; i < WARP_SIZE; i++) begin
      serve[i] = pending_q[i] && (lane_row[i] == leader_row[lane_bank[i]]);
    end
  end

  // Store merge: ascending lane order lets the highest lane win a shared byte.
  always_comb begin : store_merge
    logic [3:0]  be_l;
    logic [31:0] data_l;
    be_l   = '0;
    data_l = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      bank_be[b]    = '0;
      bank_wdata[b] = '0;
    end
    for (int i = 0; i < WARP_SIZE; i++) begin
      if (serve[i] && lane_ok[i]) begin
        be_l   = byte_en(size_q, lane_off[i]);
        data_l = wdata_q[i] << {lane_off[i], 3'b000};
        for (int k = 0; k < 4; k++) begin
          if (be_l[k]) bank_wdata[lane_bank[i]][8*k +: 8] = data_l[8*k +: 8];
        end
        bank_be[lane_bank[i]] = bank_be[lane_bank[i]] | be_l;
      end
    end
    for (int b = 0; b < NUM_BANKS; b++) begin
      bank_we[b] = (state_q == SERVE) && we_q && (bank_be[b] != 4'b0000);
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    dmem_bank #(.DEPTH(BANK_DEPTH)) u_bank (
      .clk   (clk),
      .we    (bank_we[b]),
      .addr  (leader_row[b]),
      .be    (bank_be[b]),
      .wdata (bank_wdata[b]),
      .rdata (bank_rdata[b])
    );
  end

  always_comb begin
    for (int i = 0; i < WARP_SIZE; i++) begin
      logic [31:0] word;
      word = bank_rdata[lane_bank[i]] >> {lane_off[i], 3'b000};
      case (size_q)
        MEM_BYTE: load_data[i] = {24'h0, word[7:0]};
        MEM_HALF: load_data[i] = {16'h0, word[15:0]};
        default:  load_data[i] = word;
      endcase
      if (!lane_ok[i]) load_data[i] = '0;
    end
  end

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (dmem_req) state_d = (|dmem_lane_valid) ? SERVE : RESP;
      SERVE:   if ((pending_q & ~serve) == '0) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign dmem_ready = (state_q == IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mask_q    <= '0;
      pending_q <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      size_q    <= MEM_BYTE;
      first_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && dmem_req) begin
        mask_q    <= dmem_lane_valid;
        pending_q <= dmem_lane_valid;
        addr_q    <= dmem_addr;
        wdata_q   <= dmem_wdata;
        we_q      <= dmem_we;
        size_q    <= dmem_size;
        first_q   <= 1'b1;
      end else if (state_q == SERVE) begin
        pending_q <= pending_q & ~serve;
        first_q   <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dmem_resp_valid      <= 1'b0;
      dmem_lane_resp_valid <= '0;
      dmem_rdata           <= '0;
      conflict_cycles      <= '0;
    end else begin
      dmem_resp_valid      <= (state_q == RESP);
      dmem_lane_resp_valid <= (state_q == RESP) ? mask_q : '0;
      if (state_q == SERVE && !first_q && conflict_cycles != 32'hFFFF_FFFF) begin
        conflict_cycles <= conflict_cycles + 32'd1;
      end
      if (state_q == SERVE && !we_q) begin
        for (int i = 0; i < WARP_SIZE; i++) begin
          if (serve[i]) dmem_rdata[i] <= load_data[i];
        end
      end
    end
  end

`ifdef DMEM_MISALIGN_CHK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dmem_lane_err <= '0;
    else        dmem_lane_err <= (state_q == RESP) ? (mask_q & misaligned) : '0;
  end
`endif

endmodule

// File: tb/tb_simt_dmem_responder.sv
// Directed, table-driven bench for simt_dmem_responder (default 8 banks x 1024 words).
// Define DMEM_MISALIGN_CHK_EN for both RTL and bench to exercise the error port.
module tb_simt_dmem_responder;
  import pkg_opengpu::*;

  logic                                 clk = 1'b0;
  logic                                 rst_n = 1'b0;
  logic                                 dmem_req = 1'b0;
  logic [WARP_SIZE-1:0]                 dmem_lane_valid = '0;
  logic [WARP_SIZE-1:0][ADDR_WIDTH-1:0] dmem_addr = '0;
  logic [WARP_SIZE-1:0][DATA_WIDTH-1:0] dmem_wdata = '0;
  logic                                 dmem_we = 1'b0;
  mem_size_t                            dmem_size = MEM_WORD;
  logic                                 dmem_ready;
  logic                                 dmem_resp_valid;
  logic [WARP_SIZE-1:0][DATA_WIDTH-1:0] dmem_rdata;
  logic [WARP_SIZE-1:0]                 dmem_lane_resp_valid;
  logic [31:0]                          conflict_cycles;
`ifdef DMEM_MISALIGN_CHK_EN
  logic [WARP_SIZE-1:0]                 dmem_lane_err;
`endif

  simt_dmem_responder dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .dmem_req             (dmem_req),
    .dmem_lane_valid      (dmem_lane_valid),
    .dmem_addr            (dmem_addr),
    .dmem_wdata           (dmem_wdata),
    .dmem_we              (dmem_we),
    .dmem_size            (dmem_size),
    .dmem_ready           (dmem_ready),
    .dmem_resp_valid      (dmem_resp_valid),
    .dmem_rdata           (dmem_rdata),
    .dmem_lane_resp_valid (dmem_lane_resp_valid),
    .conflict_cycles      (conflict_cycles)
`ifdef DMEM_MISALIGN_CHK_EN
    ,
    .dmem_lane_err        (dmem_lane_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       we;
    mem_size_t  size;
    logic [31:0] mask;
    logic [31:0] base;    // lane i address = base + stride*i
    logic [31:0] stride;
    logic [31:0] wbase;   // lane i store data = wbase + i
    int         exp_lat;
    logic [31:0] exp_cc;  // cumulative conflict_cycles after this request
    logic [31:0] d0;      // lane i load result = d0 + dstep*i
    logic [31:0] dstep;
  } vec_t;

  vec_t        vecs[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_rd [WARP_SIZE];

  function automatic vec_t mkv(string name, logic we, mem_size_t size, logic [31:0] mask,
                               logic [31:0] base, logic [31:0] stride, logic [31:0] wbase,
                               int exp_lat, logic [31:0] exp_cc, logic [31:0] d0,
                               logic [31:0] dstep);
    vec_t v;
    v.name = name; v.we = we; v.size = size; v.mask = mask; v.base = base;
    v.stride = stride; v.wbase = wbase; v.exp_lat = exp_lat; v.exp_cc = exp_cc;
    v.d0 = d0; v.dstep = dstep;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_rdata(input string name);
    int lane;
    lane = 0;
    for (int i = WARP_SIZE - 1; i >= 0; i--) begin
      if (dmem_rdata[i] !== exp_rd[i]) lane = i;
    end
    check($sformatf("%s rdata[%0d]", name, lane), dmem_rdata[lane], exp_rd[lane]);
  endtask

  // Drive one request, wait for acceptance, then count cycles until resp_valid.
  // Returns sampled #1 after the edge on which resp_valid rose.
  task automatic issue(input logic we, input mem_size_t size, input logic [31:0] mask,
                       input logic [31:0] base, input logic [31:0] stride,
                       input logic [31:0] wbase, output int lat);
    int n;
    for (int i = 0; i < WARP_SIZE; i++) begin
      dmem_addr[i]  = base + stride * 32'(i);
      dmem_wdata[i] = wbase + 32'(i);
    end
    dmem_lane_valid = mask;
    dmem_we         = we;
    dmem_size       = size;
    dmem_req        = 1'b1;
    n = 0;
    while (!dmem_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    @(posedge clk); #1;
    dmem_req = 1'b0;
    lat = 0;
    while (!dmem_resp_valid && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int lat;
    int saw_resp;

    for (int i = 0; i < WARP_SIZE; i++) exp_rd[i] = 32'h0;

    //                 name            we    size      mask          base      stride wbase         lat cc  d0            step
    vecs.push_back(mkv("st_stride4",   1'b1, MEM_WORD, 32'hFFFF_FFFF, 32'h1000, 32'd4,  32'h0,        5,  3,  32'h0,        32'h0));
    vecs.push_back(mkv("ld_stride4",   1'b0, MEM_WORD, 32'hFFFF_FFFF, 32'h1000, 32'd4,  32'h0,        5,  6,  32'h0,        32'h1));
    vecs.push_back(mkv("st_bcast",     1'b1, MEM_WORD, 32'h0000_0001, 32'h0100, 32'd0,  32'h55,       2,  6,  32'h0,        32'h0));
    vecs.push_back(mkv("ld_bcast",     1'b0, MEM_WORD, 32'hFFFF_FFFF, 32'h0100, 32'd0,  32'h0,        2,  6,  32'h55,       32'h0));
    vecs.push_back(mkv("ld_mask5",     1'b0, MEM_WORD, 32'h0000_0005, 32'h1000, 32'd4,  32'h0,        2,  6,  32'h0,        32'h1));
    vecs.push_back(mkv("ld_empty",     1'b0, MEM_WORD, 32'h0000_0000, 32'h1000, 32'd4,  32'h0,        1,  6,  32'h0,        32'h0));
    vecs.push_back(mkv("st_conflict",  1'b1, MEM_WORD, 32'hFFFF_FFFF, 32'h0000, 32'd32, 32'h100,      33, 37, 32'h0,        32'h0));
    vecs.push_back(mkv("ld_conflict",  1'b0, MEM_WORD, 32'hFFFF_FFFF, 32'h0000, 32'd32, 32'h0,        33, 68, 32'h100,      32'h1));
    vecs.push_back(mkv("st_clr200",    1'b1, MEM_WORD, 32'h0000_0001, 32'h0200, 32'd0,  32'h0,        2,  68, 32'h0,        32'h0));
    vecs.push_back(mkv("st_byte201",   1'b1, MEM_BYTE, 32'h0000_0001, 32'h0201, 32'd0,  32'hAB,       2,  68, 32'h0,        32'h0));
    vecs.push_back(mkv("ld_word200",   1'b0, MEM_WORD, 32'h0000_0001, 32'h0200, 32'd0,  32'h0,        2,  68, 32'h0000AB00, 32'h0));
    vecs.push_back(mkv("st_half202",   1'b1, MEM_HALF, 32'h0000_0001, 32'h0202, 32'd0,  32'hBEEF,     2,  68, 32'h0,        32'h0));
    vecs.push_back(mkv("ld_half202",   1'b0, MEM_HALF, 32'h0000_0001, 32'h0202, 32'd0,  32'h0,        2,  68, 32'h0000BEEF, 32'h0));
    vecs.push_back(mkv("ld_word200b",  1'b0, MEM_WORD, 32'h0000_0001, 32'h0200, 32'd0,  32'h0,        2,  68, 32'hBEEFAB00, 32'h0));
    vecs.push_back(mkv("st_samebyte",  1'b1, MEM_BYTE, 32'h0000_0088, 32'h0301, 32'd0,  32'hA0,       2,  68, 32'h0,        32'h0));
    vecs.push_back(mkv("ld_samebyte",  1'b0, MEM_WORD, 32'h0000_0088, 32'h0300, 32'd0,  32'h0,        2,  68, 32'h0000A718, 32'h0));

    repeat (3) @(posedge clk);
    #1;
    check("reset ready", 32'(dmem_ready), 32'd1);
    check("reset resp_valid", 32'(dmem_resp_valid), 32'd0);
    check("reset lane_resp_valid", dmem_lane_resp_valid, 32'h0);
    check("reset conflict_cycles", conflict_cycles, 32'h0);
    check_rdata("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[v]) begin
      issue(vecs[v].we, vecs[v].size, vecs[v].mask, vecs[v].base, vecs[v].stride,
            vecs[v].wbase, lat);
      if (!vecs[v].we) begin
        for (int i = 0; i < WARP_SIZE; i++) begin
          if (vecs[v].mask[i]) exp_rd[i] = vecs[v].d0 + vecs[v].dstep * 32'(i);
        end
      end
      check({vecs[v].name, " latency"}, 32'(lat), 32'(vecs[v].exp_lat));
      check({vecs[v].name, " lane_resp_valid"}, dmem_lane_resp_valid, vecs[v].mask);
      check({vecs[v].name, " conflict_cycles"}, conflict_cycles, vecs[v].exp_cc);
      check_rdata(vecs[v].name);
      @(posedge clk); #1;
      check({vecs[v].name, " pulse_end"}, 32'(dmem_resp_valid), 32'd0);
    end

    // Reset during pass 5 of a full-conflict store: passes 1-4 (lanes 0-3) persist.
    for (int i = 0; i < WARP_SIZE; i++) begin
      dmem_addr[i]  = 32'(32 * i);
      dmem_wdata[i] = 32'h900 + 32'(i);
    end
    dmem_lane_valid = 32'hFFFF_FFFF;
    dmem_we         = 1'b1;
    dmem_size       = MEM_WORD;
    dmem_req        = 1'b1;
    @(posedge clk); #1;
    dmem_req = 1'b0;
    saw_resp = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (dmem_resp_valid) saw_resp = 1;
    end
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < WARP_SIZE; i++) exp_rd[i] = 32'h0;
    check("midreset ready", 32'(dmem_ready), 32'd1);
    check("midreset conflict_cycles", conflict_cycles, 32'h0);
    check_rdata("midreset");
    repeat (40) begin
      @(posedge clk); #1;
      if (dmem_resp_valid) saw_resp = 1;
    end
    check("midreset no response", 32'(saw_resp), 32'd0);

    issue(1'b0, MEM_WORD, 32'hFFFF_FFFF, 32'h0, 32'd32, 32'h0, lat);
    for (int i = 0; i < WARP_SIZE; i++) exp_rd[i] = 32'h100 + 32'(i);
    for (int i = 0; i < 4; i++) exp_rd[i] = 32'h900 + 32'(i);
    exp_rd[16] = 32'hBEEFAB00;
    exp_rd[24] = 32'h0000A718;
    check("postreset latency", 32'(lat), 32'd33);
    check("postreset conflict_cycles", conflict_cycles, 32'd31);
    check_rdata("postreset");
    @(posedge clk); #1;

    // Misaligned WORD store at 0x102 from lane 0, then read back the aligned word.
    issue(1'b1, MEM_WORD, 32'h1, 32'h102, 32'd0, 32'h12345678, lat);
    check("misalign store latency", 32'(lat), 32'd2);
`ifdef DMEM_MISALIGN_CHK_EN
    check("misalign lane_err", dmem_lane_err, 32'h1);
`endif
    @(posedge clk); #1;
    issue(1'b0, MEM_WORD, 32'h1, 32'h100, 32'd0, 32'h0, lat);
`ifdef DMEM_MISALIGN_CHK_EN
    exp_rd[0] = 32'h0000_0108;
    check("misalign load lane_err", dmem_lane_err, 32'h0);
`else
    exp_rd[0] = 32'h1234_5678;
`endif
    check_rdata("misalign readback");
    check("final conflict_cycles", conflict_cycles, 32'd31);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
